// File: rtl/abro_channel_scheduler.sv
// Multi-channel ABRO event scheduler: per-channel A/B/R tracking with a shared,
// round-robin arbitrated 1-entry completion output (valid/ready).
//
// state  | meaning
// IDLE   | waiting for A and B
// GOT_A  | A seen, waiting for B
// GOT_B  | B seen, waiting for A
// DONE   | both seen, waiting to be loaded into the output stage
module abro_channel_scheduler #(
  parameter int N_CH = 4,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   a_in,
  input  logic [N_CH-1:0]   b_in,
  input  logic [N_CH-1:0]   r_in,
  output logic              out_valid,
  output logic [CW-1:0]     out_ch,
  input  logic              out_ready,
  output logic [N_CH-1:0]   pending,
  output logic [2*N_CH-1:0] ch_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_A = 2'b01,
    GOT_B = 2'b10,
    DONE  = 2'b11
  } ch_st_t;

  ch_st_t          st [N_CH];
  logic [CW-1:0]   rr_ptr;
  logic [N_CH-1:0] done_vec;
  logic [CW-1:0]   winner;
  logic            found;
  logic            load;

  // A channel being restarted this cycle is not eligible for the grant.
  always_comb begin
    done_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      done_vec[i] = (st[i] == DONE) && !r_in[i];
    end
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      if (!found && done_vec[(int'(rr_ptr) + k) % N_CH]) begin
        found  = 1'b1;
        winner = CW'((int'(rr_ptr) + k) % N_CH);
      end
    end
  end

  assign load = found && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) st[i] <= IDLE;
      rr_ptr    <= CW'(N_CH - 1);
      out_valid <= 1'b0;
      out_ch    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (r_in[i]) begin
          st[i] <= IDLE;
        end else begin
          case (st[i])
            IDLE: begin
              if (a_in[i] && b_in[i]) st[i] <= DONE;
              else if (a_in[i])       st[i] <= GOT_A;
              else if (b_in[i])       st[i] <= GOT_B;
            end
            GOT_A:   if (b_in[i]) st[i] <= DONE;
            GOT_B:   if (a_in[i]) st[i] <= DONE;
            DONE:    if (load && (int'(winner) == i)) st[i] <= IDLE;
            default: st[i] <= IDLE;
          endcase
        end
      end

      if (load) begin
        out_valid <= 1'b1;
        out_ch    <= winner;
        rr_ptr    <= winner;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign ch_state[2*g +: 2] = st[g];
    assign pending[g]         = (st[g] == DONE);
  end

endmodule
